// File: rtl/arb_data_mux_pkg.sv
// Shared defines and types for the arbitrated data mux.
//   `N          default number of requesting sources (overridable on the
//               command line)
//   `ARB_IW(n)  source-index width derived from a source count
// Package contents: default payload width and the FIFO occupancy encoding.

`ifndef N
`define N 8
`endif

`ifndef ARB_IW
`define ARB_IW(n) ($clog2(n))
`endif

package arb_data_mux_pkg;

  localparam int unsigned ARB_N_DFLT  = `N;
  localparam int unsigned ARB_DW_DFLT = 32;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } fifo_cnt_e;

endpackage

// File: rtl/arb_out_fifo2.sv
// Two-entry FIFO holding arbitrated {id, data[, parity]} entries.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   push, din   write strobe and entry (ignored when full)
//   pop         read strobe (ignored when empty)
//   dout        head entry (zero after reset)
//   full, empty registered occupancy flags

module arb_out_fifo2
  import arb_data_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;
  fifo_cnt_e         cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & (cnt != CNT_FULL);
  assign do_pop  = pop  & (cnt != CNT_EMPTY);

  // 1-bit pointers wrap modulo 2 by construction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= CNT_EMPTY;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= (cnt == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
        2'b01:   cnt <= (cnt == CNT_FULL)  ? CNT_ONE : CNT_EMPTY;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == CNT_EMPTY);

endmodule

// File: rtl/arb_data_mux.sv
// Arbitrated data mux: presents per-source requests to an external
// round-robin arbiter, captures the granted payload with its source index
// into a 2-entry buffer and streams it out with valid/ready.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   src_valid/src_data   per-source payloads (source i at [i*DW +: DW])
//   src_ready            per-source pop strobe (at most one bit set)
//   arb_req / arb_grant  request to / combinational grant from the arbiter
//   out_valid/data/id    head entry, held stable while stalled
//   out_ready            downstream accept
//   err_grant            sticky grant-protocol error
//   out_par              even parity of {out_id, out_data}; present only
//                        when ARB_DATA_MUX_PARITY_EN is defined

module arb_data_mux
  import arb_data_mux_pkg::*;
#(
  parameter int N  = ARB_N_DFLT,
  parameter int DW = ARB_DW_DFLT,
  parameter int IW = `ARB_IW(N)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N-1:0]        src_valid,
  input  logic [N-1:0][DW-1:0] src_data,
  output logic [N-1:0]        src_ready,
  output logic [N-1:0]        arb_req,
  input  logic [N-1:0]        arb_grant,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [IW-1:0]       out_id,
  input  logic                out_ready,
`ifdef ARB_DATA_MUX_PARITY_EN
  output logic                out_par,
`endif
  output logic                err_grant
);

`ifdef ARB_DATA_MUX_PARITY_EN
  localparam int EW = IW + DW + 1;
`else
  localparam int EW = IW + DW;
`endif

  logic          full;
  logic          empty;
  logic          gnt_multi;
  logic          gnt_orphan;
  logic          gnt_err;
  logic          push;
  logic          pop;
  logic [IW-1:0] push_id;
  logic [DW-1:0] push_data;
  logic [EW-1:0] din;
  logic [EW-1:0] dout;

  // x & (x-1) is nonzero iff more than one bit is set.
  assign gnt_multi  = |(arb_grant & (arb_grant - {{(N-1){1'b0}}, 1'b1}));
  assign gnt_orphan = !full && |(arb_grant & ~src_valid);
  assign gnt_err    = gnt_multi | gnt_orphan;

  // Gating uses the registered full flag only, so out_ready never reaches
  // arb_req/src_ready combinationally; a pop while full frees the slot for
  // the following cycle.
  assign arb_req   = (rstn && !full) ? src_valid : '0;
  assign src_ready = (rstn && !full && !gnt_err) ? (arb_grant & src_valid) : '0;
  assign push      = |src_ready;
  assign pop       = out_valid & out_ready;

  // One-hot to index and payload select from the (single) accepted source.
  always_comb begin
    push_id   = '0;
    push_data = '0;
    for (int i = 0; i < N; i++) begin
      if (src_ready[i]) begin
        push_id   = IW'(i);
        push_data = src_data[i];
      end
    end
  end

`ifdef ARB_DATA_MUX_PARITY_EN
  assign din = {^{push_id, push_data}, push_id, push_data};
  assign {out_par, out_id, out_data} = dout;
`else
  assign din = {push_id, push_data};
  assign {out_id, out_data} = dout;
`endif

  arb_out_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        err_grant <= 1'b0;
    else if (gnt_err) err_grant <= 1'b1;
  end

endmodule

// File: tb/tb_arb_data_mux.sv
// Directed bench for arb_data_mux (N=4, DW=8) with a behavioural
// round-robin arbiter and a grant override for protocol-error cases.

module tb_arb_data_mux;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      src_valid;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic [N-1:0]      arb_req;
  logic [N-1:0]      arb_grant;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic              out_ready;
  logic              err_grant;
`ifdef ARB_DATA_MUX_PARITY_EN
  logic              out_par;
`endif

  logic              frc_en;
  logic [N-1:0]      frc_gnt;
  logic [IW-1:0]     rr_last;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  arb_data_mux #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
`ifdef ARB_DATA_MUX_PARITY_EN
    .out_par   (out_par),
`endif
    .err_grant (err_grant)
  );

  // Round-robin arbiter: first requester after the last accepted source.
  always_comb begin
    arb_grant = '0;
    if (frc_en) arb_grant = frc_gnt;
    else begin
      for (int k = 1; k <= N; k++) begin
        if (arb_req[IW'(rr_last + IW'(k))] && arb_grant == '0)
          arb_grant[IW'(rr_last + IW'(k))] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_last <= IW'(N-1);
    else begin
      for (int j = 0; j < N; j++)
        if (src_ready[j]) rr_last <= IW'(j);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [DW-1:0] v);
    src_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b1;
    frc_en    = 1'b0;
    frc_gnt   = '0;

    // Reset state with requests already present; alternating two sources.
    src_valid = 4'b0101;
    set_d(0, 8'hA0);
    set_d(2, 8'hA2);
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_err",       32'(err_grant), 32'd0);
    chk("rst_arb_req",   32'(arb_req),   32'h0);
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    rstn = 1'b1;
    #1;
    chk("alt_arb_req",   32'(arb_req),   32'b0101);
    chk("alt_rdy0",      32'(src_ready), 32'b0001);
    step();
    chk("alt_v0",  32'(out_valid), 32'd1);
    chk("alt_id0", 32'(out_id),    32'd0);
    chk("alt_d0",  32'(out_data),  32'hA0);
    chk("alt_rdy1", 32'(src_ready), 32'b0100);
    step();
    chk("alt_id1", 32'(out_id),   32'd2);
    chk("alt_d1",  32'(out_data), 32'hA2);
    step();
    chk("alt_id2", 32'(out_id),   32'd0);
    chk("alt_d2",  32'(out_data), 32'hA0);
    step();
    chk("alt_id3", 32'(out_id),   32'd2);
    chk("alt_d3",  32'(out_data), 32'hA2);

    // Fill while stalled, then release; full blocks the push on the pop cycle.
    do_reset();
    src_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_d(i, 8'(8'h10 + i));
    out_ready = 1'b0;
    step();
    step();
    chk("full_arb_req", 32'(arb_req),   32'h0);
    chk("full_rdy",     32'(src_ready), 32'h0);
    chk("full_id",      32'(out_id),    32'd0);
    chk("full_data",    32'(out_data),  32'h10);
    out_ready = 1'b1;
    #1;
    chk("full_pop_req", 32'(arb_req),   32'h0);
    chk("full_pop_rdy", 32'(src_ready), 32'h0);
    step();
    chk("drain_id",   32'(out_id),    32'd1);
    chk("drain_data", 32'(out_data),  32'h11);
    chk("drain_rdy",  32'(src_ready), 32'b0100);
    step();
    chk("refill_id",  32'(out_id),    32'd2);
    chk("refill_data",32'(out_data),  32'h12);

    // Single source streaming, then a 3-cycle stall with changed input data.
    do_reset();
    src_valid = 4'b1000;
    src_data  = '0;
    set_d(3, 8'h33);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("s3_valid", 32'(out_valid), 32'd1);
      chk("s3_id",    32'(out_id),    32'd3);
    end
    out_ready = 1'b0;
    set_d(3, 8'h44);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_data", 32'(out_data), 32'h33);
      chk("stall_id",   32'(out_id),   32'd3);
    end
    out_ready = 1'b1;
    step();
    chk("unstall_data", 32'(out_data), 32'h44);

    // Multi-hot grant: error, no push, sticky until reset.
    do_reset();
    src_valid = 4'b0110;
    set_d(1, 8'h11);
    set_d(2, 8'h22);
    frc_en  = 1'b1;
    frc_gnt = 4'b0110;
    #1;
    chk("mh_rdy", 32'(src_ready), 32'h0);
    step();
    chk("mh_err",   32'(err_grant), 32'd1);
    chk("mh_valid", 32'(out_valid), 32'd0);
    frc_en = 1'b0;
    step();
    step();
    chk("mh_sticky", 32'(err_grant), 32'd1);
    chk("mh_resume", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mh_clear", 32'(err_grant), 32'd0);

    // Grant to a non-requesting source.
    step();
    src_valid = 4'b0000;
    frc_en    = 1'b1;
    frc_gnt   = 4'b0001;
    rstn      = 1'b1;
    step();
    chk("orph_err",   32'(err_grant), 32'd1);
    chk("orph_valid", 32'(out_valid), 32'd0);
    frc_en = 1'b0;

    // Asynchronous reset with a full buffer discards it.
    do_reset();
    src_valid = 4'b0011;
    set_d(0, 8'h50);
    set_d(1, 8'h51);
    out_ready = 1'b0;
    step();
    step();
    chk("ar_full_valid", 32'(out_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data",  32'(out_data),  32'h00);
    chk("ar_id",    32'(out_id),    32'd0);
    src_valid = 4'b0100;
    set_d(2, 8'h5A);
    out_ready = 1'b1;
    step();
    rstn = 1'b1;
    step();
    chk("ar_fresh_id",   32'(out_id),   32'd2);
    chk("ar_fresh_data", 32'(out_data), 32'h5A);

`ifdef ARB_DATA_MUX_PARITY_EN
    do_reset();
    src_valid = 4'b0010;
    set_d(1, 8'h01);
    step();
    chk("par_id1",  32'(out_id),  32'd1);
    chk("par_even", 32'(out_par), 32'd0);
    set_d(1, 8'h03);
    step();
    chk("par_odd",  32'(out_par), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
